mem_burst_initiator: RTL and testbench

- Initiator/master side of the 16x32 single-port memory interface (Data_in, Address, EN, W_R, Data_out, valid_out).
- Accepts a burst command (read or write, start address, beat count) over a valid/ready handshake.
- Issues one memory access per beat with a wrapping address.
- Write beats are streamed in; read data is streamed back.
- Sits between test or processing logic and the memory, replacing ad-hoc direct drive of EN/W_R.

---
 rtl/mem_burst_initiator_if.sv | 46 ++++
 rtl/mem_burst_initiator.sv | 201 ++++++++++++++++++++
 tb/tb_mem_burst_initiator.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_initiator_if.sv
// Signal bundle between the burst initiator, its command/data client and the 16x32 memory.
// The err wire exists only when MEM_RSP_TIMEOUT_EN is defined.
interface mem_burst_initiator_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wdata_valid;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_w_r;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              busy;
    logic              done;
`ifdef MEM_RSP_TIMEOUT_EN
    logic              err;
`endif

    modport master (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_len, wdata_valid, wdata, mem_rdata, mem_rvalid,
        output cmd_ready, wdata_ready, rdata_valid, rdata, mem_en, mem_w_r, mem_addr, mem_wdata,
        output busy, done
`ifdef MEM_RSP_TIMEOUT_EN
        , output err
`endif
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_addr, cmd_len, wdata_valid, wdata, mem_rdata, mem_rvalid,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, mem_en, mem_w_r, mem_addr, mem_wdata,
        input  busy, done
`ifdef MEM_RSP_TIMEOUT_EN
        , input err
`endif
    );
endinterface

// File: rtl/mem_burst_initiator.sv
// Burst initiator for the 16x32 single-port memory: one access per beat, wrapping address.
// Optional read-response watchdog (err output, TIMEOUT_CYC) enabled by MEM_RSP_TIMEOUT_EN.
module mem_burst_initiator #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
`ifdef MEM_RSP_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 8
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_burst_initiator_if.master bus
);
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, DRAIN = 2'd3} state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [CNT_W-1:0]  beats_r, beats_s;
    logic [CNT_W-1:0]  issued_r, issued_s;
    logic [CNT_W-1:0]  resp_r, resp_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_w_r_r, mem_w_r_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              rdata_valid_r, rdata_valid_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
    logic              done_r, done_s;
    logic              wr_ready_s;
    logic              rsp_take_s;
`ifdef MEM_RSP_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              err_r, err_s;
`endif

    assign wr_ready_s = (state_r == WR) && (issued_r < beats_r);
    // Responses only count while a read burst owns the memory.
    assign rsp_take_s = ((state_r == RD) || (state_r == DRAIN)) && bus.mem_rvalid;

    // Next-state, counters and next values of every registered output.
    always_comb begin
        state_s       = state_r;
        addr_s        = addr_r;
        beats_s       = beats_r;
        issued_s      = issued_r;
        resp_s        = resp_r;
        mem_en_s      = 1'b0;
        mem_w_r_s     = mem_w_r_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        rdata_valid_s = 1'b0;
        rdata_s       = rdata_r;
        done_s        = 1'b0;
`ifdef MEM_RSP_TIMEOUT_EN
        tmo_s         = tmo_r;
        err_s         = 1'b0;
`endif

        if (rsp_take_s) begin
            rdata_valid_s = 1'b1;
            rdata_s       = bus.mem_rdata;
            resp_s        = resp_r + CNT_ONE;
        end else begin
            rdata_valid_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_s   = bus.cmd_addr;
                    beats_s  = {1'b0, bus.cmd_len} + CNT_ONE;
                    issued_s = {CNT_W{1'b0}};
                    resp_s   = {CNT_W{1'b0}};
                    state_s  = bus.cmd_rd ? RD : WR;
                end else begin
                    state_s  = IDLE;
                end
            end
            WR: begin
                if (bus.wdata_valid && wr_ready_s) begin
                    mem_en_s    = 1'b1;
                    mem_w_r_s   = 1'b0;
                    mem_addr_s  = addr_r;
                    mem_wdata_s = bus.wdata;
                    addr_s      = addr_r + ADDR_ONE;
                    issued_s    = issued_r + CNT_ONE;
                    if (issued_s == beats_r) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = WR;
                    end
                end else begin
                    state_s = WR;
                end
            end
            RD: begin
                mem_en_s   = 1'b1;
                mem_w_r_s  = 1'b1;
                mem_addr_s = addr_r;
                addr_s     = addr_r + ADDR_ONE;
                issued_s   = issued_r + CNT_ONE;
                if (issued_s == beats_r) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RD;
                end
            end
            DRAIN: begin
                // Completion includes the response arriving in this very cycle.
                if (resp_s == beats_r) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

`ifdef MEM_RSP_TIMEOUT_EN
        if ((state_r == RD) || (state_r == DRAIN)) begin
            if (rsp_take_s) begin
                tmo_s = {TMO_W{1'b0}};
            end else if ((int'(tmo_r) + 1) >= TIMEOUT_CYC) begin
                err_s    = 1'b1;
                done_s   = 1'b0;
                mem_en_s = 1'b0;
                state_s  = IDLE;
                tmo_s    = {TMO_W{1'b0}};
            end else begin
                tmo_s = tmo_r + TMO_ONE;
            end
        end else begin
            tmo_s = {TMO_W{1'b0}};
        end
`else
        // Without the watchdog a silent memory holds the burst in DRAIN.
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            addr_r        <= {ADDR_W{1'b0}};
            beats_r       <= {CNT_W{1'b0}};
            issued_r      <= {CNT_W{1'b0}};
            resp_r        <= {CNT_W{1'b0}};
            mem_en_r      <= 1'b0;
            mem_w_r_r     <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            rdata_valid_r <= 1'b0;
            rdata_r       <= {DATA_W{1'b0}};
            done_r        <= 1'b0;
`ifdef MEM_RSP_TIMEOUT_EN
            tmo_r         <= {TMO_W{1'b0}};
            err_r         <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            addr_r        <= addr_s;
            beats_r       <= beats_s;
            issued_r      <= issued_s;
            resp_r        <= resp_s;
            mem_en_r      <= mem_en_s;
            mem_w_r_r     <= mem_w_r_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
            rdata_valid_r <= rdata_valid_s;
            rdata_r       <= rdata_s;
            done_r        <= done_s;
`ifdef MEM_RSP_TIMEOUT_EN
            tmo_r         <= tmo_s;
            err_r         <= err_s;
`endif
        end
    end

    assign bus.cmd_ready   = (state_r == IDLE);
    assign bus.busy        = (state_r != IDLE);
    assign bus.wdata_ready = wr_ready_s;
    assign bus.mem_en      = mem_en_r;
    assign bus.mem_w_r     = mem_w_r_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.rdata       = rdata_r;
    assign bus.done        = done_r;
`ifdef MEM_RSP_TIMEOUT_EN
    assign bus.err         = err_r;
`endif
endmodule

// File: tb/tb_mem_burst_initiator.sv
// Self-checking bench for mem_burst_initiator: directed vector table, reset/timeout sequences,
// and random bursts scored against a word-array reference of the memory.
module tb_mem_burst_initiator;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_burst_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_burst_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural 16x32 memory: registered Data_out/valid_out, W_R = 1 reads.
    logic [DW-1:0] tb_mem [NW];
    logic [DW-1:0] mem_dout   = 32'd0;
    logic          mem_vout   = 1'b0;
    bit            mem_loaded = 1'b0;
    bit            rsp_mute   = 1'b0;
    assign bus.mem_rdata  = mem_dout;
    assign bus.mem_rvalid = mem_vout;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h5A5A_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < NW; i++) tb_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end
        if (bus.mem_en === 1'b1 && bus.mem_w_r === 1'b1) begin
            mem_dout <= tb_mem[bus.mem_addr];
            mem_vout <= !rsp_mute;
        end else begin
            mem_vout <= 1'b0;
            if (bus.mem_en === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        bit          rd;
        bit [AW-1:0] addr;
        bit [AW-1:0] len;
        bit [31:0]   stall;     // bit c-1 set: no write beat offered in cycle c
        bit [DW-1:0] wbase;
        int          exp_done;  // cycle of done, counted from the handshake edge
    } vec_t;

    logic [DW-1:0] ref_mem [NW];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle in which write beat 'beat' is issued: the (beat+1)-th cycle with data offered.
    function automatic int write_issue_cycle(input bit [31:0] stall, input int beat);
        int c = 0;
        int n = -1;
        while (n < beat) begin
            c++;
            if (c > 32 || !stall[c-1]) n++;
        end
        return c;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".mem_en"}, bus.mem_en, 0);
        check({tag, ".mem_w_r"}, bus.mem_w_r, 0);
        check({tag, ".mem_addr"}, bus.mem_addr, 0);
        check({tag, ".mem_wdata"}, bus.mem_wdata, 0);
        check({tag, ".rdata_valid"}, bus.rdata_valid, 0);
        check({tag, ".rdata"}, bus.rdata, 0);
        check({tag, ".done"}, bus.done, 0);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".wdata_ready"}, bus.wdata_ready, 0);
        check({tag, ".cmd_ready"}, bus.cmd_ready, 1);
`ifdef MEM_RSP_TIMEOUT_EN
        check({tag, ".err"}, bus.err, 0);
`endif
    endtask

    task automatic run_burst(input vec_t v, input string tag);
        int nb = int'(v.len) + 1;
        logic [DW-1:0] wd [NW];
        int wi = 0;
        int n_acc = 0;
        int n_rd = 0;
        int done_cyc = -1;
        int extra = 0;
        int budget = v.exp_done + 12;
        int exp_c;
        int a;
        bit stall_c;
        for (int i = 0; i < NW; i++) wd[i] = v.wbase + 32'(i);

        @(negedge clk);
        check({tag, ".cmd_ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = v.rd;
        bus.cmd_addr  = v.addr;
        bus.cmd_len   = v.len;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check({tag, ".busy"}, bus.busy, 1);

        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            stall_c = (c <= 32) && v.stall[c-1];
            if (!v.rd && wi < nb && !stall_c) begin
                bus.wdata_valid = 1'b1;
                bus.wdata       = wd[wi];
                if (bus.wdata_ready) wi++;
            end else begin
                bus.wdata_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_en) begin
                if (n_acc < nb) begin
                    exp_c = v.rd ? n_acc + 1 : write_issue_cycle(v.stall, n_acc);
                    a = (int'(v.addr) + n_acc) % NW;
                    check({tag, ".issue_cycle"}, c, exp_c);
                    check({tag, ".mem_w_r"}, bus.mem_w_r, v.rd);
                    check({tag, ".mem_addr"}, bus.mem_addr, a);
                    if (!v.rd) check({tag, ".mem_wdata"}, bus.mem_wdata, wd[n_acc]);
                end
                n_acc++;
            end
            if (bus.rdata_valid) begin
                if (v.rd && n_rd < nb) begin
                    a = (int'(v.addr) + n_rd) % NW;
                    check({tag, ".rdata_cycle"}, c, n_rd + 3);
                    check({tag, ".rdata"}, bus.rdata, ref_mem[a]);
                end
                n_rd++;
            end
            if (bus.done) done_cyc = c;
        end
        bus.wdata_valid = 1'b0;
        check({tag, ".done_cycle"}, done_cyc, v.exp_done);
        check({tag, ".n_access"}, n_acc, nb);
        check({tag, ".n_rdata"}, n_rd, v.rd ? nb : 0);

        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_en || bus.done || bus.rdata_valid || bus.busy) extra++;
        end
        check({tag, ".quiet_after_done"}, extra, 0);

        if (!v.rd) begin
            for (int i = 0; i < nb; i++) ref_mem[(int'(v.addr) + i) % NW] = wd[i];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [9];
        vec_t v;
        int err_cyc;
        int done_seen;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);

        tbl[0] = '{1'b0, 4'd2,  4'd3,  32'd0, 32'h0000_00A0, 4};
        tbl[1] = '{1'b1, 4'd2,  4'd3,  32'd0, 32'd0,         6};
        tbl[2] = '{1'b0, 4'd14, 4'd2,  32'd0, 32'h0000_00C0, 3};
        tbl[3] = '{1'b1, 4'd14, 4'd2,  32'd0, 32'd0,         5};
        tbl[4] = '{1'b0, 4'd8,  4'd2,  32'h0000_0006, 32'h0000_00D0, 5};
        tbl[5] = '{1'b1, 4'd8,  4'd2,  32'd0, 32'd0,         5};
        tbl[6] = '{1'b1, 4'd0,  4'd15, 32'd0, 32'd0,         18};
        tbl[7] = '{1'b0, 4'd6,  4'd0,  32'd0, 32'h1234_5678, 1};
        tbl[8] = '{1'b1, 4'd6,  4'd0,  32'd0, 32'd0,         3};

        bus.cmd_valid   = 1'b0;
        bus.cmd_rd      = 1'b0;
        bus.cmd_addr    = 4'd0;
        bus.cmd_len     = 4'd0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        for (int k = 0; k < 9; k++) run_burst(tbl[k], $sformatf("vec%0d", k));

        // Reset during a 16-beat read while a competing command is held high.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = 1'b1;
        bus.cmd_addr  = 4'd0;
        bus.cmd_len   = 4'd15;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_rd   = 1'b0;
        bus.cmd_addr = 4'd9;
        bus.cmd_len  = 4'd1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst.cmd_ready", bus.cmd_ready, 0);
            check("midrst.mem_en", bus.mem_en, 1);
            check("midrst.mem_w_r", bus.mem_w_r, 1);
            check("midrst.mem_addr", bus.mem_addr, c - 1);
        end
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("midrst");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst.after_mem_en", bus.mem_en, 0);
            check("midrst.after_done", bus.done, 0);
            check("midrst.after_rdata_valid", bus.rdata_valid, 0);
        end
        run_burst('{1'b1, 4'd2, 4'd3, 32'd0, 32'd0, 6}, "postrst");

`ifdef MEM_RSP_TIMEOUT_EN
        rsp_mute = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = 1'b1;
        bus.cmd_addr  = 4'd3;
        bus.cmd_len   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        err_cyc   = -1;
        done_seen = 0;
        for (int c = 1; c <= 20 && err_cyc < 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.err) err_cyc = c;
            if (bus.done) done_seen = 1;
        end
        check("tmo.err_cycle", err_cyc, 8);
        check("tmo.no_done", done_seen, 0);
        @(posedge clk);
        @(negedge clk);
        check("tmo.busy", bus.busy, 0);
        check("tmo.err_pulse", bus.err, 0);
        rsp_mute = 1'b0;
`endif

        for (int k = 0; k < 25; k++) begin
            v.rd    = 1'($urandom_range(0, 1));
            v.addr  = 4'($urandom_range(0, 15));
            v.len   = 4'($urandom_range(0, 15));
            v.stall = $urandom() & $urandom();
            v.wbase = $urandom();
            v.exp_done = v.rd ? int'(v.len) + 3 : write_issue_cycle(v.stall, int'(v.len));
            run_burst(v, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
